// File: rtl/alu_mc_if.sv
// Request/result bundle between the control unit (master) and alu_mc (slave).
interface alu_mc_if #(
    parameter int W   = 8,
    parameter int OPW = 4
);
    logic           start;
    logic [OPW-1:0] op;
    logic [W-1:0]   inputa;
    logic [W-1:0]   inputb;
    logic           busy;
    logic           done;
    logic [W-1:0]   out;
    logic           carry;
    logic           branchflag;

    modport master (
        output start, op, inputa, inputb,
        input  busy, done, out, carry, branchflag
    );
    modport slave (
        input  start, op, inputa, inputb,
        output busy, done, out, carry, branchflag
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1-cycle logic/arith/branch ops, iterative shifts, optional
// shift-add multiplier enabled by defining ALU_MUL_EN (opcode 12 is NOP otherwise).
module alu_mc #(
    parameter int W   = 8,
    parameter int OPW = 4
) (
    input  logic    clk,
    input  logic    reset,
    alu_mc_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    localparam logic [W:0] W_VAL = (W + 1)'(W);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_LSH  = OPW'(2);
    localparam logic [OPW-1:0] OP_RSH  = OPW'(3);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6);
    localparam logic [OPW-1:0] OP_OR   = OPW'(7);
    localparam logic [OPW-1:0] OP_BGE  = OPW'(8);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(9);
    localparam logic [OPW-1:0] OP_RXOR = OPW'(10);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(11);

`ifdef ALU_MUL_EN
    localparam logic [OPW-1:0] OP_MUL  = OPW'(12);
    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t         state_q, state_d;
    logic [W-1:0]   out_q, out_d;
    logic           carry_q, carry_d;
    logic           flag_q, flag_d;
    logic           done_q, done_d;
    logic [W-1:0]   sh_q, sh_d;
    logic           left_q, left_d;
    logic [CW-1:0]  cnt_q, cnt_d;
`ifdef ALU_MUL_EN
    logic [2*W-1:0] acc_q, acc_d, acc_sum;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
`endif

    logic           sub;
    logic [W:0]     sum;
    logic [CW-1:0]  n_shift;
    logic [W:0]     first, step;
    logic [W-1:0]   imm_out;
    logic           imm_carry, imm_flag, iter;

    // Returns {bit shifted out, shifted value}; zero fill in both directions.
    function automatic logic [W:0] shift1(input logic [W-1:0] v, input logic left);
        return left ? {v, 1'b0} : {v[0], 1'b0, v[W-1:1]};
    endfunction

    // Decode of the incoming request; only consumed in IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        imm_out   = '0;
        imm_carry = 1'b0;
        imm_flag  = 1'b0;
        iter      = 1'b0;
        sub       = (bus.op == OP_SUB) || (bus.op == OP_BGE) ||
                    (bus.op == OP_BNE) || (bus.op == OP_BEQ);
        sum       = {1'b0, bus.inputa} + {1'b0, sub ? ~bus.inputb : bus.inputb}
                    + {{W{1'b0}}, sub};
        n_shift   = ({1'b0, bus.inputb} >= W_VAL) ? CW'(W) : CW'(bus.inputb);
        first     = shift1(bus.inputa, bus.op == OP_LSH);
        case (bus.op)
            OP_ADD, OP_SUB: begin
                imm_out   = sum[W-1:0];
                imm_carry = sum[W];
            end
            OP_BGE: begin
                imm_out   = sum[W-1:0];
                imm_carry = sum[W];
                imm_flag  = ~sum[W-1];
            end
            OP_BNE: begin
                imm_out   = sum[W-1:0];
                imm_carry = sum[W];
                imm_flag  = |sum[W-1:0];
            end
            OP_BEQ: begin
                imm_out   = sum[W-1:0];
                imm_carry = sum[W];
                imm_flag  = ~|sum[W-1:0];
            end
            OP_MOV:  imm_out = bus.inputb;
            OP_XOR:  imm_out = bus.inputa ^ bus.inputb;
            OP_AND:  imm_out = bus.inputa & bus.inputb;
            OP_OR:   imm_out = bus.inputa | bus.inputb;
            OP_RXOR: imm_out = {{(W-1){1'b0}}, ^bus.inputa[W-2:0]};
            OP_LSH, OP_RSH: begin
                if (n_shift == '0) begin
                    imm_out = bus.inputa;
                end else if (n_shift == CW'(1)) begin
                    imm_out   = first[W-1:0];
                    imm_carry = first[W];
                end else begin
                    iter = 1'b1;
                end
            end
`ifdef ALU_MUL_EN
            OP_MUL:  iter = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        carry_d  = carry_q;
        flag_d   = flag_q;
        done_d   = 1'b0;
        sh_d     = sh_q;
        left_d   = left_q;
        cnt_d    = cnt_q;
        step     = shift1(sh_q, left_q);
`ifdef ALU_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!iter) begin
                        out_d   = imm_out;
                        carry_d = imm_carry;
                        flag_d  = imm_flag;
                        done_d  = 1'b1;
                    end
`ifdef ALU_MUL_EN
                    else if (bus.op == OP_MUL) begin
                        acc_d    = bus.inputb[0] ? {{W{1'b0}}, bus.inputa} : '0;
                        mcand_d  = {{(W-1){1'b0}}, bus.inputa, 1'b0};
                        mplier_d = {1'b0, bus.inputb[W-1:1]};
                        cnt_d    = CW'(W - 1);
                        state_d  = MUL;
                    end
`endif
                    else begin
                        sh_d    = first[W-1:0];
                        left_d  = (bus.op == OP_LSH);
                        cnt_d   = n_shift - CW'(1);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sh_d = step[W-1:0];
                if (cnt_q == CW'(1)) begin
                    out_d   = step[W-1:0];
                    carry_d = step[W];
                    flag_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[2*W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[W-1:1]};
                if (cnt_q == CW'(1)) begin
                    out_d   = acc_sum[W-1:0];
                    carry_d = |acc_sum[2*W-1:W];
                    flag_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q  <= IDLE;
            out_q    <= '0;
            carry_q  <= 1'b0;
            flag_q   <= 1'b0;
            done_q   <= 1'b0;
            sh_q     <= '0;
            left_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef ALU_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            flag_q   <= flag_d;
            done_q   <= done_d;
            sh_q     <= sh_d;
            left_q   <= left_d;
            cnt_q    <= cnt_d;
`ifdef ALU_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.out        = out_q;
    assign bus.carry      = carry_q;
    assign bus.branchflag = flag_q;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results are queued at issue and
// compared (value, latency, busy) when done pulses.
module tb_alu_mc;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] out;
        logic         carry;
        logic         flag;
        int           lat;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_mc_if #(.W(W), .OPW(4)) ifc();
    alu_mc #(.W(W), .OPW(4)) dut (.clk(clk), .reset(reset), .bus(ifc));

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input string nm);
        exp_t e;
        logic [W:0] s;
        logic [2*W-1:0] p;
        int n;
        e.out = '0; e.carry = 1'b0; e.flag = 1'b0; e.lat = 1; e.name = nm;
        n = (int'(b) >= W) ? W : int'(b);
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; e.out = s[W-1:0]; e.carry = s[W]; end
            4'd1, 4'd8, 4'd9, 4'd11: begin
                e.out = a - b;
                e.carry = (a >= b);
                if (op == 4'd8)  e.flag = ($signed(e.out) >= 0);
                if (op == 4'd9)  e.flag = (a != b);
                if (op == 4'd11) e.flag = (a == b);
            end
            4'd2: begin
                e.out = (n >= W) ? '0 : (a << n);
                e.carry = (n == 0) ? 1'b0 : a[W-n];
                e.lat = (n <= 1) ? 1 : n;
            end
            4'd3: begin
                e.out = (n >= W) ? '0 : (a >> n);
                e.carry = (n == 0) ? 1'b0 : a[n-1];
                e.lat = (n <= 1) ? 1 : n;
            end
            4'd4:  e.out = b;
            4'd5:  e.out = a ^ b;
            4'd6:  e.out = a & b;
            4'd7:  e.out = a | b;
            4'd10: e.out = W'(^a[W-2:0]);
`ifdef ALU_MUL_EN
            4'd12: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.out = p[W-1:0];
                e.carry = (p[2*W-1:W] != '0);
                e.lat = W;
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    // Caller sits on a negedge; start stays high until the caller drops it.
    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string nm);
        ifc.start = 1'b1; ifc.op = op; ifc.inputa = a; ifc.inputb = b;
        exp_q.push_back(model(op, a, b, nm));
    endtask

    task automatic wait_done(input int elapsed);
        exp_t e;
        int cyc;
        if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL scoreboard: done awaited with nothing queued");
            return;
        end
        e = exp_q.pop_front();
        cyc = elapsed;
        while (ifc.done !== 1'b1 && cyc <= 2 * W + 4) begin
            n_checks++;
            if (ifc.busy !== 1'b1) begin
                n_errors++;
                $display("FAIL %s busy: got %b want 1 at cycle %0d", e.name, ifc.busy, cyc);
            end
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (ifc.done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s timeout: no done within %0d cycles", e.name, cyc);
            return;
        end
        n_checks++;
        if (cyc !== e.lat) begin n_errors++; $display("FAIL %s latency: got %0d want %0d", e.name, cyc, e.lat); end
        n_checks++;
        if (ifc.out !== e.out) begin n_errors++; $display("FAIL %s out: got %h want %h", e.name, ifc.out, e.out); end
        n_checks++;
        if (ifc.carry !== e.carry) begin n_errors++; $display("FAIL %s carry: got %b want %b", e.name, ifc.carry, e.carry); end
        n_checks++;
        if (ifc.branchflag !== e.flag) begin n_errors++; $display("FAIL %s flag: got %b want %b", e.name, ifc.branchflag, e.flag); end
        n_checks++;
        if (ifc.busy !== 1'b0) begin n_errors++; $display("FAIL %s busy_at_done: got %b want 0", e.name, ifc.busy); end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string nm);
        drive(op, a, b, nm);
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc.start = 1'b0; ifc.op = '0; ifc.inputa = '0; ifc.inputb = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (ifc.busy !== 1'b0) begin n_errors++; $display("FAIL reset busy: got %b want 0", ifc.busy); end
        n_checks++; if (ifc.done !== 1'b0) begin n_errors++; $display("FAIL reset done: got %b want 0", ifc.done); end
        n_checks++; if (ifc.out !== '0) begin n_errors++; $display("FAIL reset out: got %h want 00", ifc.out); end
        n_checks++; if (ifc.carry !== 1'b0) begin n_errors++; $display("FAIL reset carry: got %b want 0", ifc.carry); end
        n_checks++; if (ifc.branchflag !== 1'b0) begin n_errors++; $display("FAIL reset flag: got %b want 0", ifc.branchflag); end
    endtask

    task automatic test_single();
        run_op(4'd0,  8'hF0, 8'h20, "add_f0_20");
        run_op(4'd8,  8'h05, 8'h09, "bge_5_9");
        run_op(4'd11, 8'h07, 8'h07, "beq_7_7");
        run_op(4'd9,  8'h07, 8'h07, "bne_7_7");
        run_op(4'd9,  8'h07, 8'h03, "bne_7_3");
        run_op(4'd8,  8'h09, 8'h09, "bge_eq");
        run_op(4'd1,  8'h10, 8'h01, "sub");
        run_op(4'd4,  8'h11, 8'h5A, "mov");
        run_op(4'd5,  8'hAA, 8'h0F, "xor");
        run_op(4'd6,  8'hAA, 8'h0F, "and");
        run_op(4'd7,  8'hA0, 8'h0F, "or");
        run_op(4'd10, 8'h83, 8'h00, "rxor_msb_ignored");
        run_op(4'd10, 8'h07, 8'h00, "rxor_odd");
        run_op(4'd13, 8'hFF, 8'hFF, "nop13");
        run_op(4'd15, 8'h12, 8'h34, "nop15");
    endtask

    task automatic test_shift();
        run_op(4'd2, 8'h81, 8'd3,   "lsh_81_3");
        run_op(4'd3, 8'h81, 8'd9,   "rsh_81_9");
        run_op(4'd2, 8'hA5, 8'd0,   "lsh_n0");
        run_op(4'd3, 8'hA5, 8'd1,   "rsh_n1");
        run_op(4'd2, 8'h81, 8'd8,   "lsh_n8");
        run_op(4'd3, 8'h3C, 8'd2,   "rsh_n2");
        run_op(4'd2, 8'h01, 8'd255, "lsh_b255");
    endtask

    task automatic test_mul();
        run_op(4'd12, 8'h10, 8'h11, "mul_10_11");
        run_op(4'd12, 8'hFF, 8'hFF, "mul_ff_ff");
        run_op(4'd12, 8'h0D, 8'h0B, "mul_0d_0b");
    endtask

    task automatic test_ignore(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input string nm);
        drive(op, a, b, nm);
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = 4'd5; ifc.inputa = 8'h3C; ifc.inputb = 8'hFF;
        @(negedge clk);
        ifc.start = 1'b0; ifc.op = 4'd0; ifc.inputa = 8'h55; ifc.inputb = 8'h01;
        wait_done(2);
        @(negedge clk);
        n_checks++;
        if (ifc.done !== 1'b0) begin n_errors++; $display("FAIL %s_no_queue: done got %b want 0", nm, ifc.done); end
    endtask

    task automatic test_back_to_back();
        drive(4'd0, 8'h01, 8'h02, "b2b_add1");
        @(negedge clk);
        drive(4'd7, 8'h30, 8'h03, "b2b_or");
        wait_done(1);
        @(negedge clk);
        drive(4'd11, 8'h44, 8'h44, "b2b_beq");
        wait_done(1);
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(1);
        @(negedge clk);
        n_checks++;
        if (ifc.done !== 1'b0) begin n_errors++; $display("FAIL b2b_done_drop: got %b want 0", ifc.done); end
        drive(4'd2, 8'h81, 8'd3, "b2b_lsh");
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(1);
        drive(4'd0, 8'hFF, 8'h01, "b2b_add_after_shift");
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(1);
    endtask

    task automatic test_reset_mid();
        bit seen;
        run_op(4'd0, 8'hF0, 8'h20, "pre_reset_add");
        drive(4'd2, 8'h81, 8'd6, "aborted_lsh");
        void'(exp_q.pop_back());
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ifc.start = 1'b1; ifc.op = 4'd0; ifc.inputa = 8'h01; ifc.inputb = 8'h01;
        @(negedge clk);
        reset = 1'b0;
        ifc.start = 1'b0;
        n_checks++; if (ifc.busy !== 1'b0) begin n_errors++; $display("FAIL midreset busy: got %b want 0", ifc.busy); end
        n_checks++; if (ifc.done !== 1'b0) begin n_errors++; $display("FAIL midreset done: got %b want 0", ifc.done); end
        n_checks++; if (ifc.out !== '0) begin n_errors++; $display("FAIL midreset out: got %h want 00", ifc.out); end
        n_checks++; if (ifc.carry !== 1'b0) begin n_errors++; $display("FAIL midreset carry: got %b want 0", ifc.carry); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ifc.done === 1'b1 || ifc.busy === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_errors++; $display("FAIL midreset_quiet: got done/busy activity want none"); end
        run_op(4'd5, 8'hAA, 8'h0F, "xor_after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [3:0] op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = W'($urandom);
            if ((op == 4'd2 || op == 4'd3) && ($urandom_range(0, 1) == 1)) b = W'($urandom_range(0, 9));
            run_op(op, a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_shift();
        test_mul();
        test_ignore(4'd3, 8'h81, 8'd9, "ignore_rsh");
`ifdef ALU_MUL_EN
        test_ignore(4'd12, 8'h10, 8'h11, "ignore_mul");
`endif
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the datapath's combinational ALU. It sits between the register file read ports and the writeback/branch logic. Single-cycle operations complete with a registered result. Shifts iterate one bit per cycle and MUL is shift-add over W cycles. A Start/Busy/Done handshake lets the control unit stall the pipeline. Result, carry and branch flag are registered and held until the next completion.

## Interface
- W, default 8: datapath width (≥4).
- OPW, default 4: opcode width.
- Clk  input  1  clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; accepted only when Busy=0 and not in Reset.
- OP  input  OPW  opcode, sampled with Start.
- InputA  input  W  operand A, sampled with Start.
- InputB  input  W  operand B, sampled with Start.
- Busy  output  1  high while an iterative op is in progress.
- Done  output  1  one-cycle pulse: Out/Carry/BranchFlag just updated.
- Out  output  W  registered result, held between completions.
- Carry  output  1  registered carry/overflow, held like Out.
- BranchFlag  output  1  registered branch decision, held like Out.

## Operation
- Opcodes: ADD 0, SUB 1, LSH 2, RSH 3, MOV 4, XOR 5, AND 6, OR 7, BGE 8, BNE 9, RXOR 10, BEQ 11, MUL 12. 13–15 are NOP (Out=0, Carry=0, BranchFlag=0, 1 cycle).
- ADD: Out=A+B mod 2^W; Carry=bit W of the (W+1)-bit sum.
- SUB/BGE/BNE/BEQ: Out=A+~B+1 mod 2^W; Carry=bit W of that sum, i.e. 1 iff A≥B unsigned.
- MOV: Out=B. XOR, AND, OR: bitwise. RXOR: Out={(W-1)'b0, ^A[W-2:0]}. For these ops Carry=0.
- BranchFlag is set only for branch ops and is 0 for all others:
  - BEQ: Out==0.
  - BNE: Out!=0.
  - BGE: Out[W-1]==0, with Out==0 also qualifying.
- LSH/RSH: n=min(B,W) with B unsigned. The operand shifts one bit per cycle, zero-filled, n times. Carry=last bit shifted out, or 0 if n=0. For B≥W: Out=0, Carry=last bit shifted out at step W.
- MUL: unsigned shift-add over W iterations. Out=low W bits of A*B. Carry=1 iff the high W bits are nonzero.
- FSM states:
  - IDLE: on Start with a 1-cycle op, result registers load, Done=1, stay IDLE. On shift with n≤1, complete likewise. On shift with n≥2, latch operands, do the first shift, go SHIFT. On MUL, go MUL.
  - SHIFT: one bit per cycle; on the final step, load outputs, Done=1, go IDLE.
  - MUL: one partial product per cycle for W cycles; on the final step, load outputs, Done=1, go IDLE.
- Start while Busy=1 is ignored; no queueing.
- Operand or OP changes while Busy do not affect the op in flight, which uses latched copies.

## Timing
- Reset (any cycle, including mid-operation): next edge forces IDLE, Busy=0, Done=0, Out=0, Carry=0, BranchFlag=0, iteration counter=0. An aborted op never produces Done. Start in the same cycle as Reset is dropped.
- 1-cycle ops: Start high before edge k gives Done=1 and new Out after edge k (latency 1). Busy stays 0.
- Shift, n≥2: Busy=1 after edge k. Done=1 and Busy=0 after edge k+n-1 (latency n).
- MUL: latency W, so Busy is high for W-1 cycles.
- Back-to-back: Start may be asserted in the same cycle Done is high (Busy=0). It is accepted, giving 1 op/cycle for 1-cycle ops.
- Done is never high for two consecutive cycles unless two ops complete back-to-back.

## Configuration
- ALU_MUL_EN defined: MUL (opcode 12) implemented as above, including MUL state and partial-product register.
- ALU_MUL_EN undefined: no MUL datapath or state. Opcode 12 decodes as NOP: 1 cycle, Out=0, Carry=0, BranchFlag=0, Busy stays 0.

## Test plan
- Reset then idle: all outputs 0. ADD A=8'hF0, B=8'h20 → Done after 1 edge, Out=8'h10, Carry=1, BranchFlag=0.
- BGE A=5, B=9 → Out=8'hFC, BranchFlag=0, Carry=0. BEQ A=7, B=7 → Out=0, BranchFlag=1, Carry=1. BNE A=7, B=7 → BranchFlag=0.
- LSH A=8'h81, B=3 → Busy for 2 cycles, Done at latency 3, Out=8'h08, Carry=0. RSH A=8'h81, B=9 → latency 8, Out=0, Carry=1 (bit 7 shifted out at step 8).
- MUL A=8'h10, B=8'h11 (ALU_MUL_EN) → latency 8, Out=8'h10, Carry=1. Without the macro → latency 1, Out=0.
- Start asserted during MUL with different OP/operands → ignored; MUL result unchanged. Start in the same cycle as Done → accepted.
- Reset asserted midway through an LSH with B=6 → no Done; outputs 0 next cycle, Busy=0. A subsequent XOR 8'hAA^8'h0F gives Out=8'hA5.
